// File: rtl/store_merge_pkg.sv
// store_merge_pkg: size/state encodings and lane constants shared by store merge and load extend
package store_merge_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
  localparam logic [31:0] HALF_MASK = 32'h0000_ffff;
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;
  // True when the access cannot be done as a single aligned word-port access
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == 2'b11 || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/store_merge_lane_merge.sv
// lane_merge: replaces the addressed byte/half lane of a word with new data (little-endian)
module lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] mask;
  // Shift the lane mask and data into place, keep the rest of the old word
  always_comb begin
    sh = size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000};
    mask = (size == SZ_HALF ? HALF_MASK : size == SZ_BYTE ? BYTE_MASK : '1) << sh;
    merged = (old_word & ~mask) | ((new_data << sh) & mask);
  end
endmodule

// File: rtl/store_merge.sv
// store_merge: narrows a store and writes it to a word-only memory via read-modify-write
module store_merge
  import store_merge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rd_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wr_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q, wdata_q, merged;
  logic [1:0] size_q;
  logic [CW-1:0] cnt;
  logic berr_q, stall, tmo;
  lane_merge u_merge (
    .old_word(mem_rdata),
    .new_data(data_q),
    .size(size_q),
    .lane(addr_q[1:0]),
    .merged(merged)
  );
  // Handshake still outstanding this cycle, and whether this is its last allowed cycle
  always_comb begin
    stall = state == READ ? !mem_rd_valid : !mem_wr_ready;
    tmo = cnt == TLAST;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (req_valid) next = misaligned(req_size, req_addr[1:0]) ? ERR : req_size == SZ_WORD ? WRITE : READ;
      READ:    next = mem_rd_valid ? WRITE : tmo ? RESP : READ;
      WRITE:   next = !stall || tmo ? RESP : WRITE;
      default: next = IDLE;
    endcase
  end
  // Request capture, merged write word, timeout counter and bus-error flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      berr_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= req_size;
        wdata_q <= req_data;
      end
      if (state == READ && mem_rd_valid) wdata_q <= merged;
      if (state == READ || state == WRITE) berr_q <= stall && tmo;
      cnt <= next != state ? '0 : cnt + 1'b1;
    end
  // Outputs decoded from state
  always_comb begin
    req_ready = state == IDLE;
    done = state == RESP || state == ERR;
    misalign = state == ERR;
    bus_err = state == RESP && berr_q;
    mem_rd_en = state == READ;
    mem_wr_en = state == WRITE;
    mem_addr = addr_q[ADDR_W-1:2];
    mem_wdata = wdata_q;
  end
endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge: per-cycle timeline model of store_merge plus literal write checks
module tb_store_merge;
  localparam int TO = 16;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [31:0] req_addr = 0, req_data = 0;
  logic [1:0] req_size = 0;
  logic done, misalign, bus_err;
  logic [29:0] mem_addr;
  logic mem_rd_en, mem_wr_en;
  logic mem_rd_valid = 0, mem_wr_ready = 0;
  logic [31:0] mem_rdata, mem_wdata;
  logic [31:0] mem_word = 0;
  assign mem_rdata = mem_word;
  always #5 clk = ~clk;

  store_merge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done), .misalign(misalign), .bus_err(bus_err), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_wr_ready(mem_wr_ready)
  );

  typedef struct {
    bit rd, wr, done, mis, berr, ready, chk;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;
  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;
  exp_t q[$];
  wr_t wlog[$];
  int total = 0, bad = 0, reads = 0;
  int rd_wait = 0, wr_wait = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: answers after rd_wait/wr_wait stalled cycles, logs every accepted write
  always @(negedge clk) begin
    if (mem_rd_en) begin
      mem_rd_valid = rd_cnt == rd_wait;
      if (mem_rd_valid) reads++;
      rd_cnt++;
    end else begin
      mem_rd_valid = 0;
      rd_cnt = 0;
    end
    if (mem_wr_en) begin
      mem_wr_ready = wr_cnt == wr_wait;
      if (mem_wr_ready) wlog.push_back('{addr: mem_addr, data: mem_wdata});
      wr_cnt++;
    end else begin
      mem_wr_ready = 0;
      wr_cnt = 0;
    end
  end

  // Compare process: every cycle against the expected timeline (idle when nothing pending)
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (q.size() != 0) e = q.pop_front();
    else e = '{rd: 0, wr: 0, done: 0, mis: 0, berr: 0, ready: 1, chk: 0, addr: 0, wdata: 0};
    ok = {mem_rd_en, mem_wr_en, done, misalign, bus_err, req_ready} === {e.rd, e.wr, e.done, e.mis, e.berr, e.ready}
         && (!e.chk || mem_addr === e.addr) && (!e.wr || mem_wdata === e.wdata);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cycle t=%0t got rd=%b wr=%b done=%b mis=%b berr=%b rdy=%b addr=%h wdata=%h want rd=%b wr=%b done=%b mis=%b berr=%b rdy=%b addr=%h wdata=%h",
               $time, mem_rd_en, mem_wr_en, done, misalign, bus_err, req_ready, mem_addr, mem_wdata,
               e.rd, e.wr, e.done, e.mis, e.berr, e.ready, e.addr, e.wdata);
    end
  end

  // Expected cycle-by-cycle behaviour of one accepted request, starting the cycle after accept
  task automatic plan(input logic [31:0] a, d, input logic [1:0] sz, input int rw, ww, input logic [31:0] old);
    exp_t e;
    int sh;
    logic [31:0] m, w;
    e = '{rd: 0, wr: 0, done: 0, mis: 0, berr: 0, ready: 0, chk: 1, addr: a[31:2], wdata: 0};
    if (sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)) begin
      e.done = 1;
      e.mis = 1;
      q.push_back(e);
      return;
    end
    if (sz == 2) w = d;
    else begin
      sh = sz == 0 ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
      m = (sz == 0 ? 32'hff : 32'hffff) << sh;
      w = (old & ~m) | ((d << sh) & m);
      e.rd = 1;
      for (int i = 0; i < (rw < TO ? rw + 1 : TO); i++) q.push_back(e);
      e.rd = 0;
      if (rw >= TO) begin
        e.done = 1;
        e.berr = 1;
        q.push_back(e);
        return;
      end
    end
    e.wr = 1;
    e.wdata = w;
    for (int i = 0; i < (ww < TO ? ww + 1 : TO); i++) q.push_back(e);
    e.wr = 0;
    e.done = 1;
    e.berr = ww >= TO;
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, d, input logic [1:0] sz, input int rw, ww, input logic [31:0] old);
    rd_wait = rw;
    wr_wait = ww;
    mem_word = old;
    @(posedge clk);
    #2 req_valid = 1;
    req_addr = a;
    req_data = d;
    req_size = sz;
    @(posedge clk);
    plan(a, d, sz, rw, ww, old);
    #1 req_valid = 0;
    req_addr = a ^ 32'h4;
    req_data = ~d;
    req_size = ~sz;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1 n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic run(input logic [31:0] a, d, input logic [1:0] sz, input int rw, ww, input logic [31:0] old);
    issue(a, d, sz, rw, ww, old);
    drain();
  endtask

  task automatic expect_write(input string name, input int n0, input logic [29:0] a, input logic [31:0] d);
    check({name, "_count"}, wlog.size(), n0 + 1);
    if (wlog.size() != 0) begin
      check({name, "_addr"}, {2'b00, wlog[$].addr}, {2'b00, a});
      check({name, "_data"}, wlog[$].data, d);
    end
  endtask

  initial begin
    int n, r;
    repeat (2) @(posedge clk);
    #1 check("rst_ready", req_ready, 1);
    check("rst_outs", {done, misalign, bus_err, mem_rd_en, mem_wr_en}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(posedge clk);
    #2 rst = 0;
    n = wlog.size(); r = reads;
    run(32'h100, 32'hDEADBEEF, 2'b10, 0, 0, 32'h0);
    expect_write("word", n, 30'h40, 32'hDEADBEEF);
    check("word_noread", reads - r, 0);
    n = wlog.size(); r = reads;
    run(32'h203, 32'h000000A5, 2'b00, 0, 0, 32'h11223344);
    expect_write("byte3", n, 30'h80, 32'hA5223344);
    check("byte3_read", reads - r, 1);
    n = wlog.size();
    run(32'h202, 32'hFFFF1234, 2'b01, 0, 0, 32'hAABBCCDD);
    expect_write("half_hi", n, 30'h80, 32'h1234CCDD);
    n = wlog.size();
    run(32'h200, 32'hFFFF1234, 2'b01, 0, 0, 32'hAABBCCDD);
    expect_write("half_lo", n, 30'h80, 32'hAABB1234);
    n = wlog.size();
    run(32'h101, 32'h12345677, 2'b00, 3, 2, 32'hCAFEF00D);
    expect_write("byte1_wait", n, 30'h40, 32'hCAFE770D);
    n = wlog.size(); r = reads;
    run(32'h201, 32'h1111, 2'b01, 0, 0, 32'h0);
    run(32'h102, 32'h2222, 2'b10, 0, 0, 32'h0);
    run(32'h300, 32'h3333, 2'b11, 0, 0, 32'h0);
    check("mis_nowrite", wlog.size(), n);
    check("mis_noread", reads - r, 0);
    n = wlog.size(); r = reads;
    run(32'h400, 32'h5555, 2'b01, 100, 0, 32'h0);
    check("rd_to_nowrite", wlog.size(), n);
    check("rd_to_noread", reads - r, 0);
    n = wlog.size();
    run(32'h500, 32'h13579BDF, 2'b10, 0, 5, 32'h0);
    expect_write("wr_delay", n, 30'h140, 32'h13579BDF);
    n = wlog.size();
    run(32'h504, 32'h2468ACE0, 2'b10, 0, 100, 32'h0);
    check("wr_to_nowrite", wlog.size(), n);
    issue(32'h700, 32'h00001234, 2'b10, 0, 100, 32'h0);
    repeat (2) @(negedge clk);
    #2 q.delete();
    rst = 1;
    #1 check("rstmid_wr", mem_wr_en, 0);
    check("rstmid_ready", req_ready, 1);
    check("rstmid_done", done, 0);
    @(posedge clk);
    #2 rst = 0;
    n = wlog.size();
    run(32'h600, 32'h0F0F0F0F, 2'b10, 0, 0, 32'h0);
    expect_write("after_rst", n, 30'h180, 32'h0F0F0F0F);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
